// File: rtl/vga_info_arbiter.sv
// vga_info RAM port arbiter: posted CPU writes, CPU reads,
// VGA fetch priority with a starvation guard for the CPU.
module vga_info_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int WBUF_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              cpu_req,
  input  logic                              cpu_we,
  input  logic [ADDR_W-1:0]                 cpu_addr,
  input  logic [DATA_W-1:0]                 cpu_wdata,
  output logic                              cpu_ready,
  output logic                              cpu_rvalid,
  output logic [DATA_W-1:0]                 cpu_rdata,
  input  logic                              vga_req,
  input  logic [ADDR_W-1:0]                 vga_addr,
  output logic                              vga_gnt,
  output logic                              vga_rvalid,
  output logic [DATA_W-1:0]                 vga_rdata,
  output logic                              ram_en,
  output logic                              ram_we,
  output logic [ADDR_W-1:0]                 ram_addr,
  output logic [DATA_W-1:0]                 ram_wdata,
  input  logic [DATA_W-1:0]                 ram_rdata,
  output logic [$clog2(WBUF_DEPTH+1)-1:0]   wbuf_level
);

  localparam int LVL_W = $clog2(WBUF_DEPTH + 1);
  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [ADDR_W-1:0] wb_addr [WBUF_DEPTH];
  logic [DATA_W-1:0] wb_data [WBUF_DEPTH];

  logic [LVL_W-1:0]  level_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic              rd_pend_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [CNT_W-1:0]  starve_q;
  logic              ret_v_q;
  logic              ret_cpu_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] vga_rdata_q;

  logic wb_full;
  logic wb_empty;
  logic cpu_work;
  logic starved;
  logic cpu_gnt;
  logic wr_acc;
  logic rd_acc;
  logic push;
  logic pop;

  assign wb_full  = (level_q == LVL_W'(WBUF_DEPTH));
  assign wb_empty = (level_q == '0);
  assign cpu_work = ~wb_empty | rd_pend_q;
  assign starved  = (starve_q == CNT_W'(STARVE_MAX));

  // No traffic is started while reset is held.
  assign cpu_gnt = ~reset & cpu_work & (~vga_req | starved);
  assign vga_gnt = ~reset & ~cpu_gnt & vga_req;

  // Reads wait for an empty buffer so earlier posted writes land first.
  assign wr_acc = ~reset & cpu_req & cpu_we & ~wb_full;
  assign rd_acc = ~reset & cpu_req & ~cpu_we & wb_empty & ~rd_pend_q;

  assign cpu_ready  = wr_acc | rd_acc;
  assign push       = wr_acc;
  assign pop        = cpu_gnt & ~rd_pend_q;
  assign wbuf_level = level_q;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (1'b1)
      cpu_gnt & rd_pend_q: begin
        ram_en   = 1'b1;
        ram_addr = rd_addr_q;
      end
      cpu_gnt & ~rd_pend_q: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = wb_addr[rd_ptr_q];
        ram_wdata = wb_data[rd_ptr_q];
      end
      vga_gnt: begin
        ram_en   = 1'b1;
        ram_addr = vga_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) begin
      wb_addr[wr_ptr_q] <= cpu_addr;
      wb_data[wr_ptr_q] <= cpu_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      level_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_pend_q <= 1'b0;
      rd_addr_q <= '0;
      starve_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_q + LVL_W'(push) - LVL_W'(pop);
      if (rd_acc) begin
        rd_pend_q <= 1'b1;
        rd_addr_q <= cpu_addr;
      end else if (cpu_gnt & rd_pend_q) begin
        rd_pend_q <= 1'b0;
      end
      if (cpu_gnt | ~cpu_work)
        starve_q <= '0;
      else if (~starved)
        starve_q <= starve_q + CNT_W'(1);
    end
  end

  // Return tag: which requester owns the read data of the next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      ret_v_q     <= 1'b0;
      ret_cpu_q   <= 1'b0;
      cpu_rdata_q <= '0;
      vga_rdata_q <= '0;
    end else begin
      ret_v_q   <= ram_en & ~ram_we;
      ret_cpu_q <= cpu_gnt & rd_pend_q;
      if (cpu_rvalid) cpu_rdata_q <= ram_rdata;
      if (vga_rvalid) vga_rdata_q <= ram_rdata;
    end
  end

  assign cpu_rvalid = ~reset & ret_v_q & ret_cpu_q;
  assign vga_rvalid = ~reset & ret_v_q & ~ret_cpu_q;
  assign cpu_rdata  = cpu_rvalid ? ram_rdata : cpu_rdata_q;
  assign vga_rdata  = vga_rvalid ? ram_rdata : vga_rdata_q;

endmodule

// File: tb/tb_vga_info_arbiter.sv
// Directed bench for vga_info_arbiter with a RAM model
// that returns addr^0xFF for never-written locations.
module tb_vga_info_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ready;
  logic        cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic        vga_req;
  logic [11:0] vga_addr;
  logic        vga_gnt;
  logic        vga_rvalid;
  logic [7:0]  vga_rdata;
  logic        ram_en;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [2:0]  wbuf_level;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]    mem [4096];
  logic [4095:0] seen;

  always #5 clock = ~clock;

  vga_info_arbiter #(
    .ADDR_W(12), .DATA_W(8),
    .WBUF_DEPTH(4), .STARVE_MAX(8)
  ) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata),
    .vga_req(vga_req), .vga_addr(vga_addr),
    .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid),
    .vga_rdata(vga_rdata),
    .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .wbuf_level(wbuf_level)
  );

  always @(posedge clock) begin
    if (reset) begin
      seen <= '0;
    end else if (ram_en & ram_we) begin
      mem[ram_addr]  <= ram_wdata;
      seen[ram_addr] <= 1'b1;
    end
    if (ram_en & ~ram_we)
      ram_rdata <= seen[ram_addr] ? mem[ram_addr]
                                  : (ram_addr[7:0] ^ 8'hFF);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  int k, first, second, acc5, nwr;
  int excl_bad, stall_bad, maxlvl;
  int acc, lvl_at, rv_n, rv_c, rv_d, cpu_rv_bad;
  logic [7:0] ev;

  initial begin
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0;
    cpu_addr = '0; cpu_wdata = '0;
    vga_req = 0; vga_addr = '0;
    repeat (3) cyc();
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
    check("rst_vga_rvalid", 32'(vga_rvalid), 0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 0);
    check("rst_vga_rdata", 32'(vga_rdata), 0);
    check("rst_level", 32'(wbuf_level), 0);
    check("rst_ram_en", 32'(ram_en), 0);
    reset = 1'b0;
    cyc();

    // back-to-back writes, VGA idle
    for (int i = 0; i < 4; i++) begin
      cpu_req = 1; cpu_we = 1;
      cpu_addr = 12'h010 + 12'(i);
      cpu_wdata = 8'hA0 + 8'(i);
      #1;
      check("t1_ready", 32'(cpu_ready), 1);
      check("t1_level", 32'(wbuf_level), (i == 0) ? 0 : 1);
      check("t1_we", 32'(ram_en & ram_we), (i == 0) ? 0 : 1);
      if (i > 0)
        check("t1_addr", 32'(ram_addr), 32'h00F + 32'(i));
      cyc();
    end
    cpu_req = 0;
    #1;
    check("t1_last_we", 32'(ram_en & ram_we), 1);
    check("t1_last_addr", 32'(ram_addr), 32'h013);
    check("t1_last_data", 32'(ram_wdata), 32'hA3);
    cyc();
    check("t1_idle", 32'(ram_en), 0);
    check("t1_empty", 32'(wbuf_level), 0);

    // VGA busy: starvation guard and full-buffer stall
    vga_req = 1; vga_addr = 12'h100;
    k = 0; first = -1; second = -1; acc5 = -1; nwr = 0;
    excl_bad = 0; stall_bad = 0; maxlvl = 0;
    for (int c = 0; c < 50; c++) begin
      cpu_req = (k < 5); cpu_we = 1;
      cpu_addr = 12'h030 + 12'(k);
      cpu_wdata = 8'hB0 + 8'(k);
      #1;
      if (int'(wbuf_level) > maxlvl) maxlvl = int'(wbuf_level);
      if (ram_en & ram_we) begin
        nwr++;
        if (first < 0) begin
          first = c;
          check("t2_first_addr", 32'(ram_addr), 32'h030);
          check("t2_first_data", 32'(ram_wdata), 32'hB0);
        end else if (second < 0) begin
          second = c;
        end
      end
      if (vga_gnt == (ram_en & ram_we)) excl_bad++;
      if (cpu_req & ~cpu_ready & (wbuf_level != 3'd4))
        stall_bad++;
      if (cpu_req & cpu_ready) begin
        if (k == 4) acc5 = c;
        k++;
      end
      cyc();
    end
    check("t2_first_grant", 32'(first), 9);
    check("t2_second_grant", 32'(second), 18);
    check("t2_acc5", 32'(acc5), 10);
    check("t2_pushes", 32'(k), 5);
    check("t2_writes", 32'(nwr), 5);
    check("t2_max_level", 32'(maxlvl), 4);
    check("t2_gnt_excl", 32'(excl_bad), 0);
    check("t2_stall_full", 32'(stall_bad), 0);
    cpu_req = 0; vga_req = 0;
    cyc(); cyc();
    check("t2_drained", 32'(wbuf_level), 0);

    // RAW: write then read of same address, VGA busy
    vga_req = 1; vga_addr = 12'h200;
    cpu_req = 1; cpu_we = 1;
    cpu_addr = 12'h020; cpu_wdata = 8'h55;
    #1;
    check("t3_wr_ready", 32'(cpu_ready), 1);
    cyc();
    cpu_we = 0;
    acc = -1; lvl_at = -1; rv_n = 0; rv_c = -1; rv_d = -1;
    for (int c = 1; c < 35; c++) begin
      cpu_req = (acc < 0);
      #1;
      if (cpu_req & cpu_ready) begin
        acc = c;
        lvl_at = int'(wbuf_level);
      end
      if (cpu_rvalid) begin
        rv_n++;
        rv_c = c;
        rv_d = int'(cpu_rdata);
      end
      cyc();
    end
    check("t3_rd_accept", 32'(acc), 10);
    check("t3_rd_level", 32'(lvl_at), 0);
    check("t3_rvalid_n", 32'(rv_n), 1);
    check("t3_rvalid_at", 32'(rv_c), 20);
    check("t3_rdata", 32'(rv_d), 32'h55);
    cpu_req = 0; vga_req = 0;
    cyc(); cyc();

    // VGA-only fetches of preloaded data
    cpu_rv_bad = 0;
    for (int i = 0; i < 16; i++) begin
      vga_req = 1;
      vga_addr = 12'(i);
      #1;
      check("t4_gnt", 32'(vga_gnt), 1);
      check("t4_ram_addr", 32'(ram_addr), 32'(i));
      cyc();
      vga_req = 0;
      #1;
      ev = 8'(i) ^ 8'hFF;
      check("t4_rvalid", 32'(vga_rvalid), 1);
      check("t4_rdata", 32'(vga_rdata), 32'(ev));
      if (cpu_rvalid) cpu_rv_bad++;
      cyc();
    end
    check("t4_no_cpu_rvalid", 32'(cpu_rv_bad), 0);

    // reset right after a CPU read grant
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h020;
    #1;
    check("t5_rd_ready", 32'(cpu_ready), 1);
    cyc();
    cpu_req = 0;
    #1;
    check("t5_rd_issue", 32'(ram_en & ~ram_we), 1);
    cyc();
    reset = 1;
    #1;
    check("t5_rvalid_rst", 32'(cpu_rvalid), 0);
    cyc();
    reset = 0;
    #1;
    check("t5_rvalid_after", 32'(cpu_rvalid), 0);
    check("t5_level", 32'(wbuf_level), 0);
    cpu_req = 1; cpu_we = 1;
    cpu_addr = 12'h040; cpu_wdata = 8'h77;
    #1;
    check("t5_wr_ready", 32'(cpu_ready), 1);
    cyc();
    cpu_req = 0;
    #1;
    check("t5_wr_level", 32'(wbuf_level), 1);
    check("t5_wr_issue", 32'(ram_en & ram_we), 1);
    check("t5_wr_addr", 32'(ram_addr), 32'h040);
    cyc();
    check("t5_wr_done", 32'(wbuf_level), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_info_arbiter.md
Name: vga_info_arbiter

Overview:
- Shares the single-port VGA character/attribute RAM (vga_info region) between two requesters: CPU memory-mapped accesses and the VGA scan-out fetch engine.
- CPU writes are posted through a small write buffer, so the CPU rarely stalls.
- VGA fetches normally win the RAM port; a starvation counter guarantees CPU forward progress.
- Sits between the top-level MMIO decode (MemType == VGA_INFO) and the vga_info RAM.

Parameters:
- ADDR_W, 12, RAM word address width (4096 entries).
- DATA_W, 8, RAM data width.
- WBUF_DEPTH, 4, posted-write buffer depth in entries (power of 2, >= 2).
- STARVE_MAX, 8, consecutive denied cycles after which the CPU preempts the VGA requester (>= 1).

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  1 = write, 0 = read; qualified by cpu_req.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ready  out  1  request accepted this cycle (combinational).
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata valid.
- cpu_rdata  out  DATA_W  CPU read data.
- vga_req  in  1  VGA fetch request; held with a stable address until granted.
- vga_addr  in  ADDR_W  VGA fetch address.
- vga_gnt  out  1  VGA request issued to RAM this cycle (combinational).
- vga_rvalid  out  1  one-cycle pulse; vga_rdata valid.
- vga_rdata  out  DATA_W  VGA read data.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after a read with ram_en=1.
- wbuf_level  out  $clog2(WBUF_DEPTH+1)  current write-buffer occupancy.

Behaviour:
- Reset (synchronous) clears the write buffer, the pending CPU read, the starvation counter and the read-tag registers.
  - Registered outputs cpu_rvalid, vga_rvalid, cpu_rdata, vga_rdata and wbuf_level = 0.
  - A read in flight when reset is asserted produces no rvalid.
- CPU write acceptance: cpu_ready = cpu_req & cpu_we & (wbuf_level != WBUF_DEPTH). No same-cycle bypass when full, even if an entry drains that cycle.
- CPU read acceptance: cpu_ready = cpu_req & ~cpu_we & (wbuf_level == 0) & ~rd_pending.
  - An accepted read sets rd_pending and latches the address.
  - Because reads wait for the buffer to empty, every earlier posted write is visible to the read (RAW-safe).
- cpu_work = (wbuf_level != 0) | rd_pending.
- Grant selection, evaluated each cycle:
  - CPU wins if cpu_work & (~vga_req | starve_cnt == STARVE_MAX).
  - Otherwise VGA wins if vga_req.
  - Otherwise the RAM is idle (ram_en = 0).
- CPU grant operation: if rd_pending, issue a read and clear rd_pending; else pop the buffer head and issue a write (ram_we = 1).
  - rd_pending and a non-empty buffer are mutually exclusive by construction.
- starve_cnt: clears on a CPU grant or when cpu_work = 0; increments (saturating at STARVE_MAX) when cpu_work & ~cpu_grant.
- Read latency: a read issued at cycle t produces rvalid at t+1, with data = ram_rdata captured into the matching rdata register.
  - A one-bit tag registered at issue steers the return data to CPU or VGA.
  - Writes produce no response.
- Write-buffer push and pop in the same cycle leave wbuf_level unchanged. Pointers wrap modulo WBUF_DEPTH.
- Peak CPU write throughput is one per cycle while the buffer is not full and VGA is idle.
- VGA worst-case delay is one cycle every STARVE_MAX+1 cycles while the CPU has continuous work.
- vga_gnt is high only on the VGA grant cycle; the requester advances its address after seeing vga_gnt.

Test Plan:
- Reset, then 4 CPU writes (addr 0x010–0x013, data 0xA0–0xA3) with vga_req=0 → cpu_ready=1 on each; ram_we pulses on 4 consecutive cycles starting 1 cycle after the first accept; wbuf_level peaks at 1.
- vga_req held high continuously, CPU posts 5 writes → the 5th write is stalled (cpu_ready=0) while the buffer is full; the first CPU grant occurs exactly STARVE_MAX=8 denied cycles after the first push; vga_gnt=0 on that cycle only.
- CPU write 0x55 to addr 0x020, then an immediate read of 0x020 with VGA busy → the read is not accepted until wbuf_level==0; cpu_rvalid pulses once with cpu_rdata=0x55.
- VGA-only reads of addr 0x000–0x00F with RAM preloaded addr^0xFF → vga_rvalid pulses 1 cycle after each vga_gnt; data 0xFF, 0xFE, …; cpu_rvalid stays 0.
- Reset asserted in the cycle right after a CPU read grant → no cpu_rvalid; wbuf_level=0 next cycle; the next write is accepted normally.
